// File: rtl/alu_issue_queue.sv
`timescale 1ns/1ps
// alu_issue_queue: command FIFO in front of an external 4-bit ALU.
// Accepts {opcode,a,b} commands, issues one per cycle to the ALU while
// enabled, tracks in-flight commands for ALU_LAT cycles and captures the
// ALU result together with the originating opcode.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   enable              : permits issue from the queue
//   in_valid/in_ready   : command handshake; in_opcode, in_a, in_b payload
//   alu_reset           : ALU reset (combinational copy of reset)
//   alu_opcode/a/b      : registered ALU operands, zero when idle
//   alu_c               : ALU result
//   out_valid/out_c/out_opcode : one-cycle completion pulse + held result
//   busy                : queue non-empty or command in flight
//   done_count          : wrapping completion counter
module alu_issue_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_opcode,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       alu_reset,
    output logic [1:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [4:0] alu_c,
    output logic       out_valid,
    output logic [4:0] out_c,
    output logic [1:0] out_opcode,
    output logic       busy,
    output logic [7:0] done_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W  = 10;
    localparam int unsigned STAGES = ALU_LAT + 1;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [STAGES-1:0] trk_valid;
    logic [1:0]        trk_op [STAGES];
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    // Handshake and issue decisions depend on the registered count only,
    // so a freshly written entry cannot issue on the same edge.
    assign alu_reset = reset;
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign push      = in_valid & in_ready;
    assign pop       = enable & (count != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) | (|trk_valid);

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= {in_opcode, in_a, in_b};
        end
    end

    // Pointers, occupancy, issue registers, in-flight tracker, capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            alu_opcode <= 2'b00;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            trk_valid  <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                trk_op[i] <= 2'b00;
            end
            out_valid  <= 1'b0;
            out_c      <= 5'd0;
            out_opcode <= 2'b00;
            done_count <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (pop) begin
                {alu_opcode, alu_a, alu_b} <= head;
            end else begin
                alu_opcode <= 2'b00;
                alu_a      <= 4'd0;
                alu_b      <= 4'd0;
            end

            // Tracker shifts every edge so in-flight work drains even when
            // issue is disabled.
            trk_valid <= {trk_valid[STAGES-2:0], pop};
            trk_op[0] <= pop ? head[ENT_W-1:ENT_W-2] : 2'b00;
            for (int i = 1; i < int'(STAGES); i++) begin
                trk_op[i] <= trk_op[i-1];
            end

            out_valid <= trk_valid[STAGES-1];
            if (trk_valid[STAGES-1]) begin
                out_c      <= alu_c;
                out_opcode <= trk_op[STAGES-1];
                done_count <= done_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
`timescale 1ns/1ps
// Testbench for alu_issue_queue with a behavioural 1-cycle ALU downstream.
module tb_alu_issue_queue;

    logic       clk_tb;
    logic       reset;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_opcode;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       alu_reset;
    logic [1:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [4:0] alu_c;
    logic       out_valid;
    logic [4:0] out_c;
    logic [1:0] out_opcode;
    logic       busy;
    logic [7:0] done_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_done = 8'd0;
    logic [6:0] sb [$];

    alu_issue_queue #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk        (clk_tb),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_reset  (alu_reset),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .out_valid  (out_valid),
        .out_c      (out_c),
        .out_opcode (out_opcode),
        .busy       (busy),
        .done_count (done_count)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    // Signed 4-bit ALU reference producing a 5-bit signed result.
    function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        case (op)
            2'b00:   return {a[3], a} + {b[3], b};
            2'b01:   return {a[3], a} - {b[3], b};
            2'b10:   return {~a[3], ~a};
            default: return {4'b0000, |b};
        endcase
    endfunction

    // Downstream ALU: samples operands on an edge, C valid after it.
    always_ff @(posedge clk_tb) begin
        if (alu_reset) alu_c <= 5'd0;
        else           alu_c <= alu_ref(alu_opcode, alu_a, alu_b);
    end

    task automatic step();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_cmd();
        in_opcode = 2'($urandom_range(0, 3));
        in_a      = 4'($urandom);
        in_b      = 4'($urandom);
    endtask

    task automatic wait_out(input int max_cyc, output int cyc, output logic seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            step();
            cyc++;
            if (out_valid) seen = 1'b1;
        end
    endtask

    // One command through an idle queue: checks latency, result and counter.
    task automatic single(input string tag, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [4:0] exp_c);
        int   cyc;
        logic seen;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        step();
        in_valid = 1'b0;
        wait_out(10, cyc, seen);
        exp_done++;
        chk({tag, "_seen"}, 32'(seen), 1);
        chk({tag, "_lat"}, 32'(cyc), 3);
        chk({tag, "_c"}, 32'(out_c), 32'(exp_c));
        chk({tag, "_op"}, 32'(out_opcode), 32'(op));
        chk({tag, "_done"}, 32'(done_count), 32'(exp_done));
        step();
        chk({tag, "_pulse"}, 32'(out_valid), 0);
    endtask

    // Continuous random stream with a scoreboard; optional fill with enable low.
    task automatic stream(input string tag, input int n_cmd, input int fill,
                          output int n_res, output int first_c, output int last_c);
        int         n_push;
        logic       acc;
        logic [6:0] expv;
        n_push  = 0;
        n_res   = 0;
        first_c = -1;
        last_c  = -1;
        enable  = (fill == 0);
        new_cmd();
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (n_push >= n_cmd && sb.size() == 0) break;
            if (fill > 0 && cyc == fill) begin
                chk({tag, "_full"}, 32'(in_ready), 0);
                enable = 1'b1;
            end
            acc = in_valid & in_ready;
            step();
            if (acc) begin
                sb.push_back({in_opcode, alu_ref(in_opcode, in_a, in_b)});
                n_push++;
                if (n_push < n_cmd) new_cmd();
                else                in_valid = 1'b0;
            end
            if (out_valid) begin
                chk({tag, "_nonempty"}, 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    expv = sb.pop_front();
                    chk({tag, "_res"}, 32'({out_opcode, out_c}), 32'(expv));
                end
                n_res++;
                exp_done++;
                chk({tag, "_done"}, 32'(done_count), 32'(exp_done));
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, 32'(n_res), 32'(n_cmd));
        chk({tag, "_drained"}, 32'(sb.size()), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] q_op [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [3:0] q_a  [5] = '{4'b0001, 4'b0010, 4'b0101, 4'b1001, 4'b1111};
    logic [3:0] q_b  [5] = '{4'b0001, 4'b0101, 4'b0011, 4'b0100, 4'b1111};
    logic [4:0] q_c  [5] = '{5'b00010, 5'b11101, 5'b11010, 5'b00001, 5'b11110};

    initial begin
        int   cyc;
        logic seen;
        int   npulse;
        int   first_c;
        int   last_c;
        int   n_res;

        // Reset with in_valid high: nothing may be accepted.
        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b1;
        in_opcode = 2'b01;
        in_a      = 4'd1;
        in_b      = 4'd1;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_c", 32'(out_c), 0);
        chk("rst_out_opcode", 32'(out_opcode), 0);
        chk("rst_done", 32'(done_count), 0);
        chk("rst_alu_ops", 32'({alu_opcode, alu_a, alu_b}), 0);
        chk("rst_alu_reset", 32'(alu_reset), 1);

        // First edge with reset low accepts add 3+2.
        reset     = 1'b0;
        in_opcode = 2'b00;
        in_a      = 4'b0011;
        in_b      = 4'b0010;
        step();
        in_valid = 1'b0;
        chk("add_alu_reset", 32'(alu_reset), 0);
        chk("add_busy", 32'(busy), 1);
        chk("add_no_bypass", 32'({alu_opcode, alu_a, alu_b}), 0);
        step();
        chk("add_issue", 32'({alu_opcode, alu_a, alu_b}), 32'({2'b00, 4'b0011, 4'b0010}));
        chk("add_k1_valid", 32'(out_valid), 0);
        step();
        chk("add_k2_valid", 32'(out_valid), 0);
        chk("add_idle_ops", 32'({alu_opcode, alu_a, alu_b}), 0);
        step();
        exp_done++;
        chk("add_k3_valid", 32'(out_valid), 1);
        chk("add_c", 32'(out_c), 32'(5'b00101));
        chk("add_op", 32'(out_opcode), 0);
        chk("add_done", 32'(done_count), 1);
        step();
        chk("add_pulse", 32'(out_valid), 0);
        chk("add_hold_c", 32'(out_c), 32'(5'b00101));
        chk("add_busy_end", 32'(busy), 0);

        single("sub_m15", 2'b01, 4'b1000, 4'b0111, 5'b10001);
        single("add_p14", 2'b00, 4'b0111, 4'b0111, 5'b01110);
        single("inv", 2'b10, 4'b0101, 4'b0000, 5'b11010);
        single("orb0", 2'b11, 4'b1111, 4'b0000, 5'b00000);
        single("orb1", 2'b11, 4'b0000, 4'b1000, 5'b00001);

        // In-flight command completes even after enable drops.
        in_valid  = 1'b1;
        in_opcode = 2'b01;
        in_a      = 4'b0000;
        in_b      = 4'b0001;
        step();
        in_valid = 1'b0;
        step();
        enable = 1'b0;
        wait_out(10, cyc, seen);
        exp_done++;
        chk("dis_seen", 32'(seen), 1);
        chk("dis_lat", 32'(cyc), 2);
        chk("dis_c", 32'(out_c), 32'(5'b11111));
        step();
        chk("dis_idle", 32'(busy), 0);

        // Enable low: four accepted, fifth held, then drain in order.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_opcode = q_op[i];
            in_a      = q_a[i];
            in_b      = q_b[i];
            step();
        end
        chk("hold_full", 32'(in_ready), 0);
        in_opcode = q_op[4];
        in_a      = q_a[4];
        in_b      = q_b[4];
        step();
        step();
        chk("hold_still_full", 32'(in_ready), 0);
        chk("hold_no_issue", 32'({alu_opcode, alu_a, alu_b}), 0);
        chk("hold_no_out", 32'(out_valid), 0);
        chk("hold_busy", 32'(busy), 1);
        enable = 1'b1;
        step();
        chk("hold_ready_after_pop", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        npulse  = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (out_valid) begin
                if (npulse < 5) begin
                    chk($sformatf("hold_res%0d", npulse), 32'({out_opcode, out_c}),
                        32'({q_op[npulse], q_c[npulse]}));
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                npulse++;
            end
        end
        exp_done = exp_done + 8'd5;
        chk("hold_npulse", 32'(npulse), 5);
        chk("hold_back_to_back", 32'(last_c - first_c), 4);
        chk("hold_done", 32'(done_count), 32'(exp_done));
        chk("hold_idle", 32'(busy), 0);

        // Full queue with continuous offers and random commands.
        stream("rand50", 50, 6, n_res, first_c, last_c);

        // Reset shortly after three accepts discards all of them.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_opcode = 2'b01;
            in_a      = 4'(i + 5);
            in_b      = 4'd1;
            step();
        end
        reset = 1'b1;
        step();
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done_count), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_alu_ops", 32'({alu_opcode, alu_a, alu_b}), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_done = 8'd0;
        npulse   = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) npulse++;
        end
        chk("mid_rst_no_out", 32'(npulse), 0);
        chk("mid_rst_still_idle", 32'(busy), 0);

        // 256 completions at full throughput wrap the counter.
        stream("wrap256", 256, 0, n_res, first_c, last_c);
        chk("wrap_done_zero", 32'(done_count), 0);
        chk("wrap_throughput", 32'(last_c - first_c), 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
